// File: rtl/edge_stream_core_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
// Shared types and helpers for the streaming Sobel edge detector.
//   state_t    : frame sequencing states (IDLE, FILL, RUN, FLUSH)
//   MODE_MAG   : output saturated gradient magnitude
//   MODE_THR   : output binary threshold of the magnitude
//   window_t   : 3x3 window, element 0 = top-left (p1), raster order to p9
//   sobel_mag  : |Gx| + |Gy| of a window. It is computed at the widest
//                supported pixel width; callers truncate to PIX_W+3 bits,
//                which always holds the exact result.
// -----------------------------------------------------------------------------
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic MODE_MAG = 1'b0;
    localparam logic MODE_THR = 1'b1;

    localparam int MAX_PIX_W = 16;
    localparam int MAX_MAG_W = MAX_PIX_W + 3;

    typedef logic [8:0][MAX_PIX_W-1:0] window_t;

    function automatic logic [MAX_MAG_W-1:0] sobel_mag(input window_t win);
        logic signed [MAX_MAG_W:0] p [9];
        logic signed [MAX_MAG_W:0] gx;
        logic signed [MAX_MAG_W:0] gy;
        logic signed [MAX_MAG_W:0] ax;
        logic signed [MAX_MAG_W:0] ay;
        for (int i = 0; i < 9; i++) begin
            p[i] = $signed({{(MAX_MAG_W + 1 - MAX_PIX_W){1'b0}}, win[i]});
        end
        // Doubling by self-add keeps every term at the working width.
        gx = (p[2] + p[5] + p[5] + p[8]) - (p[0] + p[3] + p[3] + p[6]);
        gy = (p[6] + p[7] + p[7] + p[8]) - (p[0] + p[1] + p[1] + p[2]);
        ax = gx[MAX_MAG_W] ? -gx : gx;
        ay = gy[MAX_MAG_W] ? -gy : gy;
        return MAX_MAG_W'(ax + ay);
    endfunction

endpackage

// File: rtl/edge_stream_core_if.sv
// -----------------------------------------------------------------------------
// edge_stream_core_if
// Pixel stream bundle around the edge core: the input stream (i_valid,
// o_ready, i_pixel) and the output stream (o_valid, i_ready, o_pixel, o_last).
// Signal names are seen from the core.
//   master : the environment side (upstream source + downstream sink)
//   slave  : the edge core itself
// -----------------------------------------------------------------------------
interface edge_stream_core_if #(
    parameter int PIX_W = 8
) ();

    logic             i_valid;
    logic             o_ready;
    logic [PIX_W-1:0] i_pixel;
    logic             o_valid;
    logic             i_ready;
    logic [PIX_W-1:0] o_pixel;
    logic             o_last;

    modport master (
        output i_valid, i_pixel, i_ready,
        input  o_ready, o_valid, o_pixel, o_last
    );

    modport slave (
        input  i_valid, i_pixel, i_ready,
        output o_ready, o_valid, o_pixel, o_last
    );

endinterface

// File: rtl/edge_stream_core_line_buffer.sv
// -----------------------------------------------------------------------------
// edge_line_buffer
// One image row of delay. Every enabled cycle din is written and dout moves
// on to the sample written DEPTH enables earlier.
//   clk  : clock
//   rst  : synchronous active-high reset (pointer only, contents kept)
//   en   : shift enable
//   din  : sample in
//   dout : sample written DEPTH enables ago
// The read is registered: dout always holds the slot that the next write
// will overwrite, so it is fetched one enable ahead. Right after reset dout
// is 0 rather than the stale slot; that only affects the first row, which
// never reaches an interior output.
// -----------------------------------------------------------------------------
module edge_line_buffer #(
    parameter int DEPTH = 428,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr_reg;
    logic [AW-1:0]    ptr_next;
    logic [WIDTH-1:0] dout_reg;

    assign ptr_next = (ptr_reg == AW'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg  <= '0;
            dout_reg <= '0;
        end else if (en) begin
            ptr_reg  <= ptr_next;
            dout_reg <= mem[ptr_next];
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/edge_stream_core.sv
// -----------------------------------------------------------------------------
// edge_stream_core
// Streaming 3x3 Sobel edge detector: one edge pixel out per grayscale pixel
// in, raster order, full frame, border pixels forced to BORDER_VAL.
//   clk         : clock
//   rst         : synchronous active-high reset
//   bus         : input stream (i_valid/o_ready/i_pixel) and output stream
//                 (o_valid/i_ready/o_pixel/o_last)
//   i_mode      : 0 saturated magnitude, 1 binary threshold (frame start)
//   i_threshold : threshold for mode 1 (frame start)
//   o_busy      : frame in progress
// The window is completed by the live input pixel, so an output is loaded on
// the same edge that accepts the pixel completing its neighbourhood; centre k
// is visible the cycle after input k+W+1 is accepted.
// -----------------------------------------------------------------------------
module edge_stream_core
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = 428,
    parameter int IMG_HEIGHT = 428,
    parameter int PIX_W      = 8,
    parameter int BORDER_VAL = 255
) (
    input  logic              clk,
    input  logic              rst,
    edge_stream_core_if.slave bus,
    input  logic              i_mode,
    input  logic [PIX_W-1:0]  i_threshold,
    output logic              o_busy
);

    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);
    localparam int MAG_W = PIX_W + 3;

    localparam logic [CW-1:0]    LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]    LAST_ROW = RW'(IMG_HEIGHT - 1);
    localparam logic [PIX_W-1:0] BORDER   = PIX_W'(BORDER_VAL);
    localparam logic [PIX_W-1:0] PIX_MAX  = '1;

    state_t state_reg;
    state_t state_next;

    logic [CW-1:0]    in_col_reg;
    logic [RW-1:0]    in_row_reg;
    logic [CW-1:0]    out_col_reg;
    logic [RW-1:0]    out_row_reg;
    logic             mode_reg;
    logic [PIX_W-1:0] thr_reg;

    logic             o_valid_reg;
    logic             o_last_reg;
    logic [PIX_W-1:0] o_pixel_reg;

    logic free;
    logic ready;
    logic accept;
    logic load;
    logic in_wrap_col;
    logic in_last_pix;
    logic out_wrap_col;
    logic out_last_pix;
    logic border;

    assign free   = !o_valid_reg || bus.i_ready;
    assign ready  = (state_reg != FLUSH) && free;
    assign accept = bus.i_valid && ready;

    assign in_wrap_col  = (in_col_reg == LAST_COL);
    assign in_last_pix  = in_wrap_col && (in_row_reg == LAST_ROW);
    assign out_wrap_col = (out_col_reg == LAST_COL);
    assign out_last_pix = out_wrap_col && (out_row_reg == LAST_ROW);
    assign border       = (out_row_reg == '0) || (out_row_reg == LAST_ROW) ||
                          (out_col_reg == '0) || out_wrap_col;

    // ---------------- line buffers: rows r-1 and r-2 -----------------------
    logic [PIX_W-1:0] lb_in  [2];
    logic [PIX_W-1:0] lb_out [2];

    assign lb_in[0] = bus.i_pixel;
    assign lb_in[1] = lb_out[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lb
            edge_line_buffer #(
                .DEPTH (IMG_WIDTH),
                .WIDTH (PIX_W)
            ) u_lb (
                .clk  (clk),
                .rst  (rst),
                .en   (accept),
                .din  (lb_in[gi]),
                .dout (lb_out[gi])
            );
        end
    endgenerate

    // ---------------- 3x3 window ------------------------------------------
    // col_new is column c of rows r-2..r for the pixel being offered;
    // col0/col1 hold columns c-1 and c-2 from earlier accepts.
    logic [PIX_W-1:0] col_new  [3];
    logic [PIX_W-1:0] col0_reg [3];
    logic [PIX_W-1:0] col1_reg [3];
    window_t          win;
    logic [MAG_W-1:0] mag;
    logic [PIX_W-1:0] pix_next;

    assign col_new[0] = lb_out[1];
    assign col_new[1] = lb_out[0];
    assign col_new[2] = bus.i_pixel;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                col0_reg[i] <= '0;
                col1_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                col1_reg[i] <= col0_reg[i];
                col0_reg[i] <= col_new[i];
            end
        end
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < 3; i++) begin
            win[3*i]     = MAX_PIX_W'(col1_reg[i]);
            win[3*i + 1] = MAX_PIX_W'(col0_reg[i]);
            win[3*i + 2] = MAX_PIX_W'(col_new[i]);
        end
    end

    assign mag = MAG_W'(sobel_mag(win));

    always_comb begin
        pix_next = BORDER;
        if (!border) begin
            if (mode_reg == MODE_THR) begin
                pix_next = (mag >= MAG_W'(thr_reg)) ? PIX_MAX : '0;
            end else begin
                pix_next = (mag > MAG_W'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
            end
        end
    end

    // ---------------- FSM -------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = FILL;
            end
            FILL: begin
                // pixel index W is (row 1, col 0): first centre now complete
                if (accept && (in_col_reg == '0) && (in_row_reg == RW'(1))) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                load = accept;
                if (accept && in_last_pix) state_next = FLUSH;
            end
            FLUSH: begin
                // remaining W+1 centres are all border, no input needed
                load = free;
                if (free && out_last_pix) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- counters and frame parameters -------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            in_col_reg  <= '0;
            in_row_reg  <= '0;
            out_col_reg <= '0;
            out_row_reg <= '0;
            mode_reg    <= MODE_MAG;
            thr_reg     <= '0;
        end else begin
            if (accept) begin
                if (state_reg == IDLE) begin
                    mode_reg <= i_mode;
                    thr_reg  <= i_threshold;
                end
                in_col_reg <= in_wrap_col ? '0 : in_col_reg + 1'b1;
                if (in_wrap_col) begin
                    in_row_reg <= in_last_pix ? '0 : in_row_reg + 1'b1;
                end
            end
            if (load) begin
                out_col_reg <= out_wrap_col ? '0 : out_col_reg + 1'b1;
                if (out_wrap_col) begin
                    out_row_reg <= out_last_pix ? '0 : out_row_reg + 1'b1;
                end
            end
        end
    end

    // ---------------- output register --------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_reg <= 1'b0;
            o_last_reg  <= 1'b0;
            o_pixel_reg <= '0;
        end else if (load) begin
            o_valid_reg <= 1'b1;
            o_last_reg  <= out_last_pix;
            o_pixel_reg <= pix_next;
        end else if (bus.i_ready) begin
            o_valid_reg <= 1'b0;
            o_last_reg  <= 1'b0;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = o_valid_reg;
    assign bus.o_pixel = o_pixel_reg;
    assign bus.o_last  = o_last_reg;
    assign o_busy      = (state_reg != IDLE);

endmodule
